// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and response multiplexer.
// Decodes HADDR into a one-hot slave select, tracks which slave owns the
// current data phase, and multiplexes that slave's response back to the
// master. Unmapped NONSEQ/SEQ transfers get the standard two-cycle ERROR
// response from an internal default slave.
module ahb_decoder_mux #(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {3{32'hF000_0000}}
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  // Master address/data phase
  input  logic [ADDR_WIDTH-1:0]          HADDR,
  input  logic [1:0]                     HTRANS,
  input  logic                           HWRITE,
  input  logic [2:0]                     HSIZE,
  input  logic [2:0]                     HBURST,
  input  logic [3:0]                     HPROT,
  input  logic                           HMASTLOCK,
  input  logic [DATA_WIDTH-1:0]          HWDATA,
  // Muxed response to master
  output logic [DATA_WIDTH-1:0]          HRDATA,
  output logic                           HREADY,
  output logic [1:0]                     HRESP,
  // Slave-side select and broadcast bus
  output logic [NUM_SLAVES-1:0]          HSEL_S,
  output logic                           HREADY_S,
  output logic [ADDR_WIDTH-1:0]          HADDR_S,
  output logic [1:0]                     HTRANS_S,
  output logic                           HWRITE_S,
  output logic [2:0]                     HSIZE_S,
  output logic [2:0]                     HBURST_S,
  output logic [3:0]                     HPROT_S,
  output logic                           HMASTLOCK_S,
  output logic [DATA_WIDTH-1:0]          HWDATA_S,
  // Slave responses, slot i belongs to slave i
  input  logic [NUM_SLAVES-1:0]          HREADYOUT_S,
  input  logic [2*NUM_SLAVES-1:0]        HRESP_S,
  input  logic [DATA_WIDTH*NUM_SLAVES-1:0] HRDATA_S
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t              ds_state;
  ds_state_t              ds_state_nxt;
  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic                   owner_def;
  logic [IDX_W-1:0]       owner_idx;
  logic                   hready_int;
  logic                   slv_ready;
  logic [1:0]             slv_resp;
  logic [DATA_WIDTH-1:0]  slv_rdata;

  // Address and control are broadcast to every slave untouched.
  assign HADDR_S     = HADDR;
  assign HTRANS_S    = HTRANS;
  assign HWRITE_S    = HWRITE;
  assign HSIZE_S     = HSIZE;
  assign HBURST_S    = HBURST;
  assign HPROT_S     = HPROT;
  assign HMASTLOCK_S = HMASTLOCK;
  assign HWDATA_S    = HWDATA;

  // Decode: scan downwards so the lowest-indexed matching slave wins overlaps.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    HSEL_S  = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((HADDR & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit       = 1'b1;
        hit_idx   = IDX_W'(i);
        HSEL_S    = '0;
        HSEL_S[i] = 1'b1;
      end
    end
  end

  // Data-phase owner: loads with every accepted address phase, holds through waits.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_def <= 1'b1;
      owner_idx <= '0;
    end else if (hready_int) begin
      owner_def <= ~hit;
      owner_idx <= hit_idx;
    end
  end

  // Default-slave state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ds_state <= DS_OKAY;
    else          ds_state <= ds_state_nxt;
  end

  // Default-slave next state: ERR1 always advances to ERR2; otherwise an
  // accepted unmapped active transfer starts a new error, anything else is OKAY.
  always_comb begin
    ds_state_nxt = ds_state;
    case (ds_state)
      DS_ERR1: ds_state_nxt = DS_ERR2;
      default: begin
        if (hready_int) begin
          if (!hit && HTRANS[1]) ds_state_nxt = DS_ERR1;
          else                   ds_state_nxt = DS_OKAY;
        end
      end
    endcase
  end

  // Select the owning slave's response slot.
  always_comb begin
    slv_ready = 1'b1;
    slv_resp  = 2'b00;
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (owner_idx == IDX_W'(i)) begin
        slv_ready = HREADYOUT_S[i];
        slv_resp  = HRESP_S[2*i +: 2];
        slv_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Response to master: default slave when nothing was hit, else the owning slave.
  always_comb begin
    if (owner_def) begin
      hready_int = (ds_state != DS_ERR1);
      HRESP      = (ds_state == DS_OKAY) ? 2'b00 : 2'b01;
      HRDATA     = '0;
    end else begin
      hready_int = slv_ready;
      HRESP      = slv_resp;
      HRDATA     = slv_rdata;
    end
  end

  assign HREADY   = hready_int;
  assign HREADY_S = hready_int;

endmodule
